// File: rtl/rv_plic_src_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_plic_src_pkg
// Description : Shared constants and types for the PLIC source-conditioning
//               filter (rv_plic_src_filter / rv_plic_src_chan).
// Revision    : 1.0 - initial release
// ============================================================================
package rv_plic_src_pkg;

  localparam int SRC_CNT_W_DEFAULT       = 4;
  localparam int SRC_SYNC_STAGES_DEFAULT = 2;

  // Width of the default glitch counter.
  localparam int SRC_CNT_W = SRC_CNT_W_DEFAULT;
  typedef logic [SRC_CNT_W-1:0] src_cnt_t;

  // STABLE while the counter is zero; CHECK while a candidate change is being timed.
  typedef enum logic [0:0] {
    SRC_STABLE = 1'b0,
    SRC_CHECK  = 1'b1
  } src_chan_state_e;

endpackage
`default_nettype wire

// File: rtl/rv_plic_src_chan.sv
`default_nettype none
// ============================================================================
// Module      : rv_plic_src_chan
// Description : One interrupt-source channel: polarity inversion, synchroniser,
//               optional glitch counter (RV_PLIC_SRC_GLITCH_FILT_EN) and a
//               registered rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_plic_src_chan
  import rv_plic_src_pkg::*;
#(
  parameter int SYNC_STAGES = SRC_SYNC_STAGES_DEFAULT,
  parameter int CNT_W       = SRC_CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             raw_i,
  input  logic             inv_i,
  input  logic             filt_en_i,
  input  logic [CNT_W-1:0] filt_len_i,
  output logic             out_o,
  output logic             rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;

  // Inversion happens before the first flop so the chain carries the active level.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i ^ inv_i};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State register: synchroniser, conditioned level and rise pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      out_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      out_q  <= out_d;
      rise_q <= rise_d;
    end
  end

`ifdef RV_PLIC_SRC_GLITCH_FILT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  src_chan_state_e  chan_state;

  assign chan_state = (cnt_q == '0) ? SRC_STABLE : SRC_CHECK;

  // Counter register; cleared by reset even in the middle of a check.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Next-state: a change must be seen for L+1 consecutive samples before it is accepted.
  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    if (!filt_en_i || (filt_len_i == '0)) begin
      out_d = s;
      cnt_d = '0;
    end else if (s == out_q) begin
      cnt_d = '0;
    end else if (cnt_q >= filt_len_i) begin
      // >= rather than == so a shortened length takes effect on the next edge.
      out_d = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // A channel can only be timing a change if the filter was enabled on the previous edge.
  a_check_needs_filter : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (chan_state == SRC_CHECK) |-> $past(filt_en_i)
  );
`else
  // Without the filter every channel is a straight synchronised bypass.
  always_comb begin
    out_d = s;
  end

  // Configuration inputs are kept on the port list but have no function here.
  logic unused_filt_cfg;
  assign unused_filt_cfg = ^{filt_en_i, filt_len_i};
`endif

  // Output decode: pulse in the same cycle the registered level first reads 1.
  always_comb begin
    rise_d = out_d & ~out_q;
  end

  assign out_o  = out_q;
  assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/rv_plic_src_filter.sv
`default_nettype none
// ============================================================================
// Module      : rv_plic_src_filter
// Description : Per-source interrupt conditioning ahead of rv_plic. Builds the
//               glitch counters only when RV_PLIC_SRC_GLITCH_FILT_EN is
//               defined; otherwise every source is a synchronised bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_plic_src_filter
  import rv_plic_src_pkg::*;
#(
  parameter int N_SOURCE    = 32,
  parameter int SYNC_STAGES = SRC_SYNC_STAGES_DEFAULT,
  parameter int CNT_W       = SRC_CNT_W_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] intr_src_i,
  input  logic [N_SOURCE-1:0] inv_i,
  input  logic [N_SOURCE-1:0] filt_en_i,
  input  logic [CNT_W-1:0]    filt_len_i,
  output logic [N_SOURCE-1:0] intr_src_o,
  output logic [N_SOURCE-1:0] rise_o
);

  // One independent channel per source; the filter length is shared.
  for (genvar i = 0; i < N_SOURCE; i++) begin : g_chan
    rv_plic_src_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .raw_i      (intr_src_i[i]),
      .inv_i      (inv_i[i]),
      .filt_en_i  (filt_en_i[i]),
      .filt_len_i (filt_len_i),
      .out_o      (intr_src_o[i]),
      .rise_o     (rise_o[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_plic_src_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_plic_src_filter
// Description : Self-checking bench for rv_plic_src_filter: directed latency,
//               glitch and inversion scenarios plus randomized traffic against
//               a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_plic_src_filter;

  localparam int N  = 32;
  localparam int SS = 2;
  localparam int CW = 4;
`ifdef RV_PLIC_SRC_GLITCH_FILT_EN
  localparam bit FILT_BUILT = 1'b1;
`else
  localparam bit FILT_BUILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  raw, inv, fen;
  logic [CW-1:0] flen;
  logic [N-1:0]  dut_out, dut_rise;

  always #5 clk = ~clk;

  rv_plic_src_filter #(
    .N_SOURCE    (N),
    .SYNC_STAGES (SS),
    .CNT_W       (CW)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .intr_src_i (raw),
    .inv_i      (inv),
    .filt_en_i  (fen),
    .filt_len_i (flen),
    .intr_src_o (dut_out),
    .rise_o     (dut_rise)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural model: the filter sees the active level SS edges late; a new level is
  // accepted once it has already disagreed with the output for at least L samples.
  logic [N-1:0] m_out = '0;
  logic [N-1:0] m_rise = '0;
  int           m_run[N];
  logic [N-1:0] m_xq[$];

  task automatic model_edge();
    logic [N-1:0] s, nxt;
    if (rst) begin
      m_xq.delete();
      for (int k = 0; k < SS; k++) m_xq.push_back('0);
      m_out  = '0;
      m_rise = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      s   = m_xq[0];
      nxt = m_out;
      for (int i = 0; i < N; i++) begin
        if (!(FILT_BUILT && fen[i] && (flen != 0))) begin
          nxt[i]   = s[i];
          m_run[i] = 0;
        end else if (s[i] == m_out[i]) begin
          m_run[i] = 0;
        end else if (m_run[i] >= int'(flen)) begin
          nxt[i]   = s[i];
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
        end
      end
      m_rise = nxt & ~m_out;
      m_out  = nxt;
      void'(m_xq.pop_front());
      m_xq.push_back(raw ^ inv);
    end
  endtask

  // One clock edge: advance the model, then compare both outputs just after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("out", dut_out, m_out);
    chk("rise", dut_rise, m_rise);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rises;
    int dens;

    // Reset with all inputs high; outputs must stay low.
    rst = 1'b1; raw = '1; inv = '0; fen = '0; flen = '0;
    repeat (3) begin
      step();
      chk("rst_out", dut_out, '0);
      chk("rst_rise", dut_rise, '0);
    end

    // Bypass release: all ones after SS+1 edges, one rise pulse on every bit.
    rst = 1'b0;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      lat++;
      if (dut_out === '1) break;
    end
    chk("byp_lat", N'(lat), N'(SS + 1));
    chk("byp_rise", dut_rise, '1);
    step();
    chk("byp_rise_once", dut_rise, '0);

    // Filtered rise on source 5 with L=4.
    raw = '0; fen = '1; flen = 4'd4;
    repeat (12) step();
    raw[5] = 1'b1;
    lat = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      lat++;
      if (dut_out[5] === 1'b1) break;
    end
    chk("filt_lat", N'(lat), N'(SS + 1 + (FILT_BUILT ? 4 : 0)));
    chk("filt_rise5", N'(dut_rise[5]), N'(1));

    // Glitch of 4 samples is rejected when filtered; 5 samples pass.
    raw = '0;
    repeat (12) step();
    for (int w = 4; w <= 5; w++) begin
      rises = 0;
      raw[5] = 1'b1;
      repeat (w) begin step(); rises += int'(dut_rise[5]); end
      raw[5] = 1'b0;
      repeat (15) begin step(); rises += int'(dut_rise[5]); end
      chk((w == 4) ? "glitch4_rises" : "glitch5_rises", N'(rises),
          N'((w == 4 && FILT_BUILT) ? 0 : 1));
    end

    // Inversion on source 7: idle-low raw reads active, raw high drops without a rise.
    inv[7] = 1'b1;
    repeat (15) step();
    chk("inv7_high", N'(dut_out[7]), N'(1));
    raw[7] = 1'b1;
    rises = 0;
    repeat (15) begin step(); rises += int'(dut_rise[7]); end
    chk("inv7_low", N'(dut_out[7]), N'(0));
    chk("inv7_no_rise", N'(rises), N'(0));
    raw[7] = 1'b0; inv[7] = 1'b0;
    repeat (15) step();

    // Mid-count length change: L=10, count reaches 6, then L=3 flips on the next edge.
    flen = 4'd10;
    raw[5] = 1'b1;
    repeat (8) step();
    chk("midlen_hold", N'(dut_out[5]), N'(FILT_BUILT ? 0 : 1));
    flen = 4'd3;
    step();
    chk("midlen_flip", N'(dut_out[5]), N'(1));

    // Mid-count reset followed by a clean restart.
    raw[5] = 1'b0; flen = 4'd10;
    repeat (20) step();
    raw[5] = 1'b1;
    repeat (6) step();
    rst = 1'b1;
    step();
    chk("midrst_out", dut_out, '0);
    rst = 1'b0;
    repeat (20) step();

    // Randomized traffic with occasional resets, length and enable changes.
    dens = 4;
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) dens = int'($urandom_range(1, 12));
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) flen = CW'($urandom);
      if ($urandom_range(0, 99) == 0) fen = N'($urandom);
      if ($urandom_range(0, 299) == 0) inv = N'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, dens) == 0) raw[i] = ~raw[i];
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
